// File: rtl/pc_adder_pkg.sv
// ============================================================================
// Module  : pc_adder_pkg
// Purpose : Shared constants and types for the PC-increment adder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_adder_pkg;

  localparam int PC_WIDTH  = 32;
  localparam int PC_INC    = 4;
  localparam int CLA_GROUP = 4;

  typedef logic [PC_WIDTH-1:0] pc_t;

endpackage

`default_nettype wire

// File: rtl/cla_block4.sv
// ============================================================================
// Module  : cla_block4
// Purpose : 4-bit carry-lookahead block; exports group generate/propagate.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cla_block4 (
  input  logic [3:0] a,
  input  logic [3:0] k,
  input  logic       ci,
  output logic [3:0] s,
  output logic       gg,
  output logic       gp
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  assign w_g = a & k;
  assign w_p = a ^ k;

  // Each internal carry is a flat two-level expression of g/p and ci.
  assign w_c[0] = ci;
  assign w_c[1] = w_g[0] | (w_p[0] & ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & ci);

  assign s  = w_p ^ w_c;
  assign gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
            | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign gp = &w_p;

endmodule

`default_nettype wire

// File: rtl/adder_pc_no_offset.sv
// ============================================================================
// Module  : adder_pc_no_offset
// Purpose : Registered next-PC adder, sum = a + INC + cin, two-level CLA.
//           Optional macro ADDER_PC_OVF_EN adds a registered signed-overflow
//           output ovf.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module adder_pc_no_offset
  import pc_adder_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int INC   = PC_INC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_PC_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int              NB    = WIDTH / CLA_GROUP;
  localparam logic [WIDTH-1:0] c_inc = WIDTH'(INC);

  logic [NB-1:0]    w_grp_g;
  logic [NB-1:0]    w_grp_p;
  logic [NB:0]      w_blk_c;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  // Carry into block j, fully expanded over all lower blocks (no ripple).
  function automatic logic block_carry(input logic [NB-1:0] g,
                                       input logic [NB-1:0] p,
                                       input logic          c0,
                                       input int            j);
    logic r;
    logic t;
    t = c0;
    for (int m = 0; m < NB; m++) begin
      if (m < j) t = t & p[m];
    end
    r = t;
    for (int i = 0; i < NB; i++) begin
      if (i < j) begin
        t = g[i];
        for (int m = 0; m < NB; m++) begin
          if ((m > i) && (m < j)) t = t & p[m];
        end
        r = r | t;
      end
    end
    return r;
  endfunction

  generate
    for (genvar j = 0; j < NB; j++) begin : g_blk
      cla_block4 u_cla (
        .a  (a[j*CLA_GROUP +: CLA_GROUP]),
        .k  (c_inc[j*CLA_GROUP +: CLA_GROUP]),
        .ci (w_blk_c[j]),
        .s  (w_s[j*CLA_GROUP +: CLA_GROUP]),
        .gg (w_grp_g[j]),
        .gp (w_grp_p[j])
      );
    end

    for (genvar j = 0; j <= NB; j++) begin : g_blk_carry
      assign w_blk_c[j] = block_carry(w_grp_g, w_grp_p, cin, j);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_s;
      r_cout <= w_blk_c[NB];
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

`ifdef ADDER_PC_OVF_EN
  logic w_c_msb;
  logic r_ovf;

  // Carry into the MSB recovered from the MSB sum bit: s = a ^ k ^ c.
  assign w_c_msb = a[WIDTH-1] ^ c_inc[WIDTH-1] ^ w_s[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_c_msb ^ w_blk_c[NB];
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adder_pc_no_offset.sv
// ============================================================================
// Module  : tb_adder_pc_no_offset
// Purpose : Self-checking bench for adder_pc_no_offset (arithmetic model).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_adder_pc_no_offset;
  import pc_adder_pkg::*;

  localparam int W = 32;
  localparam int K = 4;

  logic         clk;
  logic         rst_n;
  pc_t          a;
  logic         cin;
  pc_t          sum;
  logic         cout;
`ifdef ADDER_PC_OVF_EN
  logic         ovf;
`endif

  int checks;
  int errors;

  // Expected registered outputs, from plain arithmetic on captured inputs.
  pc_t  m_sum;
  logic m_cout;
  logic m_ovf;

  adder_pc_no_offset #(.WIDTH(W), .INC(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout)
`ifdef ADDER_PC_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    m_sum  = '0;
    m_cout = 1'b0;
    m_ovf  = 1'b0;
  end

  always @(posedge clk or negedge rst_n) begin
    logic [W:0] full;
    if (!rst_n) begin
      m_sum  = '0;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      full   = {1'b0, a} + (W+1)'(K) + (W+1)'(cin);
      m_sum  = full[W-1:0];
      m_cout = full[W];
      // Adding a positive amount overflows only from non-negative to negative.
      m_ovf  = ~a[W-1] & full[W-1];
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_sum", 64'(sum), 64'(0));
      check("rst_cout", 64'(cout), 64'(0));
    end else begin
      check("model_sum", 64'(sum), 64'(m_sum));
      check("model_cout", 64'(cout), 64'(m_cout));
`ifdef ADDER_PC_OVF_EN
      check("model_ovf", 64'(ovf), 64'(m_ovf));
`endif
    end
  end

  task automatic drive(input pc_t av, input logic cv);
    a   = av;
    cin = cv;
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    a      = '0;
    cin    = 1'b0;
    #1;
    check("reset_sum", 64'(sum), 64'(0));
    check("reset_cout", 64'(cout), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;

    drive(32'h0000_0005, 1'b0);
    check("d1_sum", 64'(sum), 64'h0000_0009);
    check("d1_cout", 64'(cout), 64'(0));
    drive(32'h0000_00FF, 1'b1);
    check("d2_sum", 64'(sum), 64'h0000_0104);
    check("d2_cout", 64'(cout), 64'(0));
    drive(32'hFFFF_FFFF, 1'b0);
    check("wrap_sum", 64'(sum), 64'h0000_0003);
    check("wrap_cout", 64'(cout), 64'(1));
    drive(32'hFFFF_FFFF, 1'b1);
    check("wrap1_sum", 64'(sum), 64'h0000_0004);
    check("wrap1_cout", 64'(cout), 64'(1));
    drive(32'h8000_0000, 1'b0);
    check("msb_sum", 64'(sum), 64'h8000_0004);
    check("msb_cout", 64'(cout), 64'(0));
    drive(32'h7FFF_FFFC, 1'b0);
    check("ovf_sum", 64'(sum), 64'h8000_0000);
`ifdef ADDER_PC_OVF_EN
    check("ovf_flag", 64'(ovf), 64'(1));
`endif
    drive(32'h0FFF_FFFB, 1'b0);
    check("chain_sum", 64'(sum), 64'h0FFF_FFFF);
    drive(32'h0FFF_FFFB, 1'b1);
    check("chain1_sum", 64'(sum), 64'h1000_0000);

    for (int n = 0; n < 10000; n++) begin
      drive(pc_t'($urandom), 1'($urandom_range(0, 1)));
    end

    drive(32'h1234_5678, 1'b1);
    check("hold_sum", 64'(sum), 64'h1234_567D);
    check("hold_cout", 64'(cout), 64'(0));
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_sum", 64'(sum), 64'(0));
    check("async_rst_cout", 64'(cout), 64'(0));
    a   = '0;
    cin = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("post_rst_sum", 64'(sum), 64'h0000_0004);
    check("post_rst_cout", 64'(cout), 64'(0));

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
